// File: rtl/lowx_mem_responder.sv
// lowX block responder: fetches a cache line (or one uncached word) from a
// single-word memory port as sequential transactions and returns the
// assembled block on the lowX response channel.
module lowx_mem_responder #(
   parameter int XLEN     = 32,
   parameter int BLK_SIZE = 128
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic [XLEN-1:0]     req_addr_i,
   input  logic                req_uncached_i,
   output logic                res_valid_o,
   input  logic                res_ready_i,
   output logic [BLK_SIZE-1:0] res_blk_o,
   output logic                mem_req_o,
   input  logic                mem_gnt_i,
   output logic [XLEN-1:0]     mem_addr_o,
   input  logic                mem_rvalid_i,
   input  logic [XLEN-1:0]     mem_rdata_i
);

   localparam int WORDS = BLK_SIZE / XLEN;
   localparam int BW    = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t              state_reg;
   logic [XLEN-1:0]     base_reg;
   logic                uncached_reg;
   logic [BW-1:0]       lane_reg;
   logic [BW-1:0]       beat_reg;
   logic [XLEN-1:0]     buf_reg [WORDS];

   logic                accept;
   logic                buf_we;
   logic                last_beat;
   logic [BW-1:0]       wr_idx;
   logic [BW-1:0]       beat_inc;
   logic [XLEN-1:0]     line_base;
   logic [XLEN-1:0]     word_base;

   // Ready only in IDLE, and never while reset is held.
   assign req_ready_o = (state_reg == ST_IDLE) && !rst_i;
   assign accept      = req_valid_i && req_ready_o;
   assign buf_we      = (state_reg == ST_WAIT) && mem_rvalid_i;
   assign last_beat   = uncached_reg || (beat_reg == BW'(WORDS - 1));
   assign wr_idx      = uncached_reg ? lane_reg : beat_reg;
   assign beat_inc    = beat_reg + 1'b1;
   // Masking keeps every address bit in use; the low bits are simply dropped.
   assign line_base   = req_addr_i & ~XLEN'(BLK_SIZE / 8 - 1);
   assign word_base   = req_addr_i & ~XLEN'(3);

   // Control FSM with registered memory-request and response outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg    <= ST_IDLE;
         base_reg     <= '0;
         uncached_reg <= 1'b0;
         lane_reg     <= '0;
         beat_reg     <= '0;
         mem_req_o    <= 1'b0;
         mem_addr_o   <= '0;
         res_valid_o  <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (accept) begin
                  base_reg     <= req_uncached_i ? word_base : line_base;
                  uncached_reg <= req_uncached_i;
                  lane_reg     <= req_addr_i[2 +: BW];
                  beat_reg     <= '0;
                  mem_req_o    <= 1'b1;
                  mem_addr_o   <= req_uncached_i ? word_base : line_base;
                  state_reg    <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (mem_gnt_i) begin
                  mem_req_o <= 1'b0;
                  state_reg <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (mem_rvalid_i) begin
                  if (last_beat) begin
                     res_valid_o <= 1'b1;
                     state_reg   <= ST_RESP;
                  end else begin
                     // Line-aligned base, so the beat offset never carries upward.
                     beat_reg   <= beat_inc;
                     mem_addr_o <= base_reg + XLEN'({beat_inc, 2'b00});
                     mem_req_o  <= 1'b1;
                     state_reg  <= ST_ISSUE;
                  end
               end
            end
            ST_RESP: begin
               if (res_ready_i) begin
                  res_valid_o <= 1'b0;
                  state_reg   <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // Block buffer: one register per word, cleared on accept, written per beat.
   generate
      for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
         always_ff @(posedge clk_i) begin
            if (rst_i || accept) begin
               buf_reg[gi] <= '0;
            end else if (buf_we && (wr_idx == BW'(gi))) begin
               buf_reg[gi] <= mem_rdata_i;
            end
         end
         assign res_blk_o[gi*XLEN +: XLEN] = buf_reg[gi];
      end
   endgenerate

endmodule

// File: tb/tb_lowx_mem_responder.sv
// Directed bench for lowx_mem_responder with a behavioural memory and a
// scoreboard of expected memory addresses and response blocks.
module tb_lowx_mem_responder;

   logic         clk = 1'b0;
   logic         rst_i;
   logic         req_valid_i;
   logic         req_ready_o;
   logic [31:0]  req_addr_i;
   logic         req_uncached_i;
   logic         res_valid_o;
   logic         res_ready_i;
   logic [127:0] res_blk_o;
   logic         mem_req_o;
   logic         mem_gnt_i;
   logic [31:0]  mem_addr_o;
   logic         mem_rvalid_i;
   logic [31:0]  mem_rdata_i;

   lowx_mem_responder #(.XLEN(32), .BLK_SIZE(128)) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_addr_i     (req_addr_i),
      .req_uncached_i (req_uncached_i),
      .res_valid_o    (res_valid_o),
      .res_ready_i    (res_ready_i),
      .res_blk_o      (res_blk_o),
      .mem_req_o      (mem_req_o),
      .mem_gnt_i      (mem_gnt_i),
      .mem_addr_o     (mem_addr_o),
      .mem_rvalid_i   (mem_rvalid_i),
      .mem_rdata_i    (mem_rdata_i)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [31:0]  exp_addr_q [$];
   logic [127:0] exp_blk_q  [$];

   // memory model configuration and spurious-pulse controls (written by main)
   int   gnt_delay = 0;
   int   rv_delay  = 1;
   bit   force_rv  = 1'b0;
   bit   force_gnt = 1'b0;
   int   gnt_count = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a[31]) return (32'(a[3:2]) + 32'd1) * 32'h1111_1111;
      return 32'hDEAD_BEEF + (a - 32'h3000_0008);
   endfunction

   function automatic logic [127:0] exp_block(input logic [31:0] a, input logic u);
      logic [127:0] b;
      logic [31:0]  lb;
      int           ln;
      b = '0;
      if (u) begin
         ln = int'(a[3:2]);
         b[ln*32 +: 32] = mem_word(a & ~32'h3);
      end else begin
         lb = a & ~32'hF;
         for (int k = 0; k < 4; k++) b[k*32 +: 32] = mem_word(lb + 32'(4 * k));
      end
      return b;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Memory model plus protocol monitor and scoreboard, evaluated on negedge.
   initial begin
      bit           busy = 1'b0;
      bit           rv_pending = 1'b0;
      int           rv_cnt = 0;
      int           gnt_wait = 0;
      logic [31:0]  rv_addr = '0;
      logic [31:0]  ea;
      logic         prev_mem_req = 1'b0, prev_gnt = 1'b0;
      logic         prev_res_valid = 1'b0, prev_res_ready = 1'b0;
      logic [31:0]  prev_addr = '0;
      logic [127:0] prev_blk = '0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      forever begin
         @(negedge clk);
         if (rst_i) begin
            exp_addr_q.delete();
            exp_blk_q.delete();
            busy = 1'b0; rv_pending = 1'b0; gnt_wait = 0;
            mem_gnt_i = 1'b0; mem_rvalid_i = force_rv; mem_rdata_i = 32'hBAD0_BAD0;
            prev_mem_req = 1'b0; prev_res_valid = 1'b0; prev_gnt = 1'b0;
         end else begin
            if (prev_mem_req && !prev_gnt) begin
               chk("mem_req_hold", 128'(mem_req_o), 128'd1);
               chk("mem_addr_hold", 128'(mem_addr_o), 128'(prev_addr));
            end
            if (prev_res_valid && !prev_res_ready) begin
               chk("res_valid_hold", 128'(res_valid_o), 128'd1);
               chk("res_blk_hold", res_blk_o, prev_blk);
            end
            if (res_valid_o || mem_req_o) chk("req_ready_busy", 128'(req_ready_o), 128'd0);
            if (req_valid_i && req_ready_o) begin
               chk("accept_when_idle", 128'(busy), 128'd0);
               busy = 1'b1;
               exp_blk_q.push_back(exp_block(req_addr_i, req_uncached_i));
               if (req_uncached_i) exp_addr_q.push_back(req_addr_i & ~32'h3);
               else for (int k = 0; k < 4; k++)
                  exp_addr_q.push_back((req_addr_i & ~32'hF) + 32'(4 * k));
            end
            if (res_valid_o && res_ready_i) begin
               if (exp_blk_q.size() == 0) chk("res_unexpected", 128'd1, 128'd0);
               else chk("res_blk", res_blk_o, exp_blk_q.pop_front());
               $display("RESP blk=%h", res_blk_o);
               busy = 1'b0;
            end
            mem_gnt_i = force_gnt; mem_rvalid_i = force_rv; mem_rdata_i = 32'hBAD0_BAD0;
            if (rv_pending) begin
               if (rv_cnt == 0) begin
                  mem_rvalid_i = 1'b1;
                  mem_rdata_i  = mem_word(rv_addr);
                  rv_pending   = 1'b0;
               end else rv_cnt--;
            end else if (mem_req_o) begin
               if (gnt_wait >= gnt_delay) begin
                  mem_gnt_i  = 1'b1;
                  gnt_wait   = 0;
                  rv_pending = 1'b1;
                  rv_cnt     = rv_delay - 1;
                  rv_addr    = mem_addr_o;
                  gnt_count++;
                  if (exp_addr_q.size() == 0) chk("mem_addr_unexpected", 128'd1, 128'd0);
                  else begin
                     ea = exp_addr_q.pop_front();
                     chk("mem_addr", 128'(mem_addr_o), 128'(ea));
                  end
                  $display("MEM  addr=%h", mem_addr_o);
               end else gnt_wait++;
            end
            prev_mem_req   = mem_req_o;
            prev_addr      = mem_addr_o;
            prev_gnt       = mem_gnt_i;
            prev_res_valid = res_valid_o;
            prev_res_ready = res_ready_i;
            prev_blk       = res_blk_o;
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Drive one request until accepted; return cycles from accept to res_valid.
   task automatic do_req(input logic [31:0] a, input logic u, output int lat);
      int n;
      req_addr_i = a; req_uncached_i = u; req_valid_i = 1'b1;
      n = 0;
      while (!req_ready_o && n < 100) begin step(); n++; end
      step();
      req_valid_i = 1'b0;
      lat = 1;
      while (!res_valid_o && lat < 300) begin step(); lat++; end
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int lat;
      int n;
      int g0;
      rst_i = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; req_uncached_i = 1'b0;
      res_ready_i = 1'b0;
      repeat (3) step();
      chk("rst_req_ready", 128'(req_ready_o), 128'd0);
      chk("rst_res_valid", 128'(res_valid_o), 128'd0);
      chk("rst_mem_req", 128'(mem_req_o), 128'd0);
      chk("rst_mem_addr", 128'(mem_addr_o), 128'd0);
      chk("rst_blk", res_blk_o, 128'd0);
      rst_i = 1'b0;
      step();
      chk("idle_ready", 128'(req_ready_o), 128'd1);

      // 1: cached, zero-wait memory
      res_ready_i = 1'b1;
      do_req(32'h8000_0014, 1'b0, lat);
      chk("cached_latency", 128'(lat), 128'd9);
      step();
      chk("cached_blk_hold", res_blk_o, 128'h44444444_33333333_22222222_11111111);
      chk("cached_done_valid", 128'(res_valid_o), 128'd0);

      // 2: uncached word
      do_req(32'h3000_0008, 1'b1, lat);
      chk("uncached_latency", 128'(lat), 128'd3);
      step();
      chk("uncached_blk_hold", res_blk_o, 128'h00000000_DEADBEEF_00000000_00000000);

      // 3: grant and rvalid backpressure, response stalled 5 cycles
      gnt_delay = 3; rv_delay = 2; res_ready_i = 1'b0;
      do_req(32'h8000_0100, 1'b0, lat);
      chk("bp_latency", 128'(lat), 128'd25);
      repeat (4) begin
         step();
         chk("bp_res_valid", 128'(res_valid_o), 128'd1);
         chk("bp_req_ready", 128'(req_ready_o), 128'd0);
      end
      res_ready_i = 1'b1;
      step();
      chk("bp_released", 128'(res_valid_o), 128'd0);

      // 4: back-to-back with request held high and fields changing while busy
      gnt_delay = 0; rv_delay = 1; res_ready_i = 1'b0;
      req_addr_i = 32'h8000_0040; req_uncached_i = 1'b0; req_valid_i = 1'b1;
      n = 0;
      while (!req_ready_o && n < 100) begin step(); n++; end
      step();
      req_addr_i = 32'h8000_0084; req_uncached_i = 1'b1;
      lat = 1;
      while (!res_valid_o && lat < 300) begin step(); lat++; end
      chk("b2b_first_latency", 128'(lat), 128'd9);
      repeat (2) step();
      res_ready_i = 1'b1;
      step();
      chk("b2b_ready_after_hs", 128'(req_ready_o), 128'd1);
      step();
      req_valid_i = 1'b0;
      chk("b2b_second_issue", 128'(mem_req_o), 128'd1);
      chk("b2b_second_addr", 128'(mem_addr_o), 128'h8000_0084);
      lat = 1;
      while (!res_valid_o && lat < 300) begin step(); lat++; end
      chk("b2b_second_latency", 128'(lat), 128'd3);
      step();

      // 5: reset while waiting on beat 1, then a stray rvalid
      rv_delay = 4;
      g0 = gnt_count;
      req_addr_i = 32'h8000_0200; req_uncached_i = 1'b0; req_valid_i = 1'b1;
      n = 0;
      while (!req_ready_o && n < 100) begin step(); n++; end
      step();
      req_valid_i = 1'b0;
      n = 0;
      while (gnt_count < g0 + 2 && n < 200) begin step(); n++; end
      chk("rst_reached_beat1", 128'(gnt_count - g0), 128'd2);
      rst_i = 1'b1;
      step();
      chk("midrst_req_ready", 128'(req_ready_o), 128'd0);
      chk("midrst_res_valid", 128'(res_valid_o), 128'd0);
      chk("midrst_mem_req", 128'(mem_req_o), 128'd0);
      chk("midrst_mem_addr", 128'(mem_addr_o), 128'd0);
      chk("midrst_blk", res_blk_o, 128'd0);
      step();
      rst_i = 1'b0;
      step();
      force_rv = 1'b1;
      step();
      force_rv = 1'b0;
      step();
      chk("stray_blk", res_blk_o, 128'd0);
      chk("stray_ready", 128'(req_ready_o), 128'd1);
      chk("stray_mem_req", 128'(mem_req_o), 128'd0);
      rv_delay = 1; res_ready_i = 1'b1;
      do_req(32'h8000_0300, 1'b0, lat);
      chk("post_rst_latency", 128'(lat), 128'd9);
      step();

      // 6: spurious gnt/rvalid in IDLE and in RESP
      force_rv = 1'b1; force_gnt = 1'b1;
      step();
      force_rv = 1'b0; force_gnt = 1'b0;
      step();
      chk("spur_idle_blk", res_blk_o, exp_block(32'h8000_0300, 1'b0));
      chk("spur_idle_ready", 128'(req_ready_o), 128'd1);
      chk("spur_idle_mem_req", 128'(mem_req_o), 128'd0);
      res_ready_i = 1'b0;
      do_req(32'h8000_0404, 1'b1, lat);
      chk("spur_unc_latency", 128'(lat), 128'd3);
      force_rv = 1'b1; force_gnt = 1'b1;
      step();
      force_rv = 1'b0; force_gnt = 1'b0;
      step();
      chk("spur_resp_valid", 128'(res_valid_o), 128'd1);
      chk("spur_resp_blk", res_blk_o, 128'h00000000_00000000_22222222_00000000);
      res_ready_i = 1'b1;
      step();
      chk("spur_resp_done", 128'(res_valid_o), 128'd0);

      repeat (3) step();
      chk("scoreboard_empty", 128'(exp_blk_q.size() + exp_addr_q.size()), 128'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lowx_mem_responder.md
Name: lowx_mem_responder

Overview:
- Memory-side responder for the cache-to-lower-level interface. It accepts one lowX block request (valid/ready, addr, uncached) at a time.
- It fetches the data from a 32-bit word-wide memory port as sequential single-word transactions.
- It assembles a BLK_SIZE-bit block and returns it on the lowX response channel (valid/ready, blk).
- It sits between the instruction/data cache miss path and main memory (PMA region 0x8000_0000).

Parameters:
- XLEN, 32, address and memory data width.
- BLK_SIZE, 128, cache line width in bits. Must be a power of two and a multiple of XLEN.
- WORDS, BLK_SIZE/XLEN (=4), derived; beats per cached line.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  lowX request valid.
- req_ready_o  out  1  responder can accept a request.
- req_addr_i  in  XLEN  request byte address.
- req_uncached_i  in  1  1 = fetch only the addressed word.
- res_valid_o  out  1  block response valid.
- res_ready_i  in  1  cache accepts response.
- res_blk_o  out  BLK_SIZE  returned block; word k occupies bits [32k+31:32k].
- mem_req_o  out  1  memory read request.
- mem_gnt_i  in  1  memory accepts request this cycle.
- mem_addr_o  out  XLEN  word-aligned memory address.
- mem_rvalid_i  in  1  read data valid (one per granted request, latency >=1 cycle after grant).
- mem_rdata_i  in  XLEN  read data.

Behaviour:
- One clock (clk_i). Reset is synchronous and active-high (rst_i). All state updates on the rising edge.
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- Reset values: req_ready_o=0 while rst_i=1, res_valid_o=0, mem_req_o=0, mem_addr_o=0, res_blk_o=0, beat counter=0.
- IDLE: req_ready_o=1 (when rst_i=0). On req_valid_i&req_ready_o:
  - latch base address. Cached: addr with low log2(BLK_SIZE/8) bits cleared. Uncached: addr with bits[1:0] cleared.
  - latch the uncached flag and lane=addr[3:2].
  - set beat=0 and clear the block buffer to 0.
  - go to ISSUE.
- ISSUE: mem_req_o=1, mem_addr_o=base+4*beat (uncached: base). Held stable until mem_gnt_i. On mem_gnt_i go to WAIT.
- WAIT: mem_req_o=0. On mem_rvalid_i:
  - write mem_rdata_i into buffer word [beat] (cached) or word [lane] (uncached); other words keep their value.
  - If last beat (uncached, or beat==WORDS-1) go to RESP; else beat++ and go to ISSUE.
- RESP: res_valid_o=1. res_blk_o=buffer, held stable until res_ready_i. On res_ready_i go to IDLE. req_ready_o=0 in this cycle; no accept-and-respond overlap.
- Uncached responses: non-addressed words are 0.
- res_blk_o always reflects the buffer register. It holds its last value after RESP until the next accept clears it.
- mem_rvalid_i outside WAIT is ignored. mem_gnt_i outside ISSUE is ignored.
- Request fields change while req_ready_o=0: ignored. Only the accept-cycle values are used.
- Beat address wraps within 32 bits (base+4*beat never carries into tag since base is line-aligned).
- Minimum latency with grant in ISSUE cycle and rvalid one cycle later:
  - accept at cycle T.
  - cached: res_valid_o at T+1+2*WORDS (T+9).
  - uncached: res_valid_o at T+3.
- Reset asserted in any state: next cycle state=IDLE and outputs at reset values. In-flight memory data is discarded; rvalid arriving in IDLE is ignored.
- Exactly one outstanding memory transaction and one outstanding lowX request at any time.

Test Plan:
1. Cached, zero-wait memory (gnt same cycle, rvalid +1). Request addr 0x8000_0014, mem[w]=w*0x11111111.
   - mem_addr_o sequence: 0x8000_0010, 0x8000_0014, 0x8000_0018, 0x8000_001C.
   - res_blk_o=0x44444444_33333333_22222222_11111111-style packing, word0 at bits[31:0].
   - res_valid_o at T+9.
2. Uncached request addr 0x3000_0008, mem returns 0xDEADBEEF.
   - single mem_req_o to 0x3000_0008.
   - res_blk_o=0x00000000_DEADBEEF_00000000_00000000.
   - res_valid_o at T+3.
3. Backpressure: grant delayed 3 cycles per beat, rvalid delayed 2 cycles; res_ready_i held low 5 cycles in RESP.
   - mem_addr_o and mem_req_o stable while waiting.
   - res_blk_o and res_valid_o stable until res_ready_i.
   - req_ready_o=0 throughout.
4. Back-to-back: second req_valid_i held high from the cycle after the first accept.
   - second request accepted only in the cycle after the first res handshake.
   - first block unaffected.
5. Reset mid-operation: assert rst_i in WAIT after beat 1; deliver a stray rvalid 1 cycle after reset release.
   - state IDLE, all outputs 0 during reset, stray rvalid ignored.
   - next request completes correctly.
6. Spurious inputs: pulse mem_rvalid_i and mem_gnt_i in IDLE and RESP → no state or buffer change.
